// File: rtl/pseudo_sensor_pkg.sv
// Shared defaults, FSM states and beat tag for the core-side frame reader.
package pseudo_sensor_pkg;
  localparam int PKG_IMG_W      = 640;
  localparam int PKG_IMG_H      = 480;
  localparam int PKG_ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } beat_tag_t;

  localparam int TAG_W = $bits(beat_tag_t);
endpackage

// File: rtl/stream_return_fifo.sv
// First-word-fall-through FIFO holding returned pixels with their beat tags.
// Push when full and pop when empty are ignored; the reader's issue budget keeps both from happening.
module stream_return_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             head_vld_o,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// File: rtl/core_frame_reader.sv
// Walks a decimated ROI of the readable frame bank on each swap pulse and streams it out
// with sof/eol/eof markers; reads are only issued while the return FIFO can absorb them.
module core_frame_reader
  import pseudo_sensor_pkg::*;
#(
  parameter int ADDR_WIDTH = PKG_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = PKG_IMG_W,
  parameter int IMG_H      = PKG_IMG_H,
  parameter int OUT_W      = 28,
  parameter int OUT_H      = 28,
  parameter int X0         = 250,
  parameter int Y0         = 170,
  parameter int STEP       = 5,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  c_clk,
  input  logic                  arst_c_n,
  input  logic                  swap_c,
  input  logic [3:0]            image_num_c,
  output logic [ADDR_WIDTH-1:0] addr_c,
  input  logic [DATA_WIDTH-1:0] dout_c,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic [3:0]            m_image_num,
  output logic                  busy,
  output logic                  overrun
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W = $clog2(OUT_W + 1);
  localparam int ROW_W = $clog2(OUT_H + 1);
  localparam int FW    = TAG_W + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ROW_START = ADDR_WIDTH'(Y0 * IMG_W + X0);
  localparam logic [ADDR_WIDTH-1:0] COL_INC   = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ROW_INC   = ADDR_WIDTH'(STEP * IMG_W);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(OUT_H - 1);

  if (X0 + (OUT_W - 1) * STEP >= IMG_W) begin : g_bad_roi_x
    $error("ROI exceeds frame width");
  end
  if (Y0 + (OUT_H - 1) * STEP >= IMG_H) begin : g_bad_roi_y
    $error("ROI exceeds frame height");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least RD_LAT+2");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [3:0]            img_q, img_d;
  logic                  overrun_q, overrun_d;
  logic [RD_LAT-1:0]     pipe_vld_q;
  beat_tag_t             pipe_tag_q [RD_LAT];

  logic [CNT_W-1:0]      inflight, fifo_count;
  logic [CNT_W:0]        budget_used;
  logic                  issue, last_col, last_row, pop, fifo_vld;
  beat_tag_t             iss_tag, head_tag;
  logic [DATA_WIDTH-1:0] head_data;
  logic [FW-1:0]         fifo_head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe_vld_q[i]);
  end

  // Budget counts the FIFO before this cycle's pop, so it is conservative by one slot at most.
  assign budget_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state_q == RUN) && (budget_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign last_col    = (col_q == COL_LAST);
  assign last_row    = (row_q == ROW_LAST);
  assign iss_tag     = '{sof: (col_q == '0) && (row_q == '0), eol: last_col, eof: last_col && last_row};
  assign pop         = fifo_vld && m_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    img_d      = img_q;
    overrun_d  = swap_c && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (swap_c) begin
          state_d    = RUN;
          img_d      = image_num_c;
          row_base_d = ROW_START;
          addr_d     = ROW_START;
          col_d      = '0;
          row_d      = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (!last_col) begin
            addr_d = addr_q + COL_INC;
            col_d  = col_q + COL_W'(1);
          end else if (last_row) begin
            state_d = DRAIN;
          end else begin
            row_base_d = row_base_q + ROW_INC;
            addr_d     = row_base_q + ROW_INC;
            col_d      = '0;
            row_d      = row_q + ROW_W'(1);
          end
        end
      end
      DRAIN: begin
        if ((inflight == '0) &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge arst_c_n) begin
    if (!arst_c_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      img_q      <= '0;
      overrun_q  <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      img_q      <= img_d;
      overrun_q  <= overrun_d;
      pipe_vld_q[0] <= issue;
      pipe_tag_q[0] <= iss_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  stream_return_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk_i      (c_clk),
    .rst_ni     (arst_c_n),
    .push_i     (pipe_vld_q[RD_LAT-1]),
    .push_dat_i ({pipe_tag_q[RD_LAT-1], dout_c}),
    .pop_i      (pop),
    .head_vld_o (fifo_vld),
    .head_dat_o (fifo_head),
    .count_o    (fifo_count)
  );

  assign {head_tag, head_data} = fifo_head;

  assign addr_c      = addr_q;
  assign m_valid     = fifo_vld;
  assign m_data      = fifo_vld ? head_data : '0;
  assign m_sof       = fifo_vld && head_tag.sof;
  assign m_eol       = fifo_vld && head_tag.eol;
  assign m_eof       = fifo_vld && head_tag.eof;
  assign m_image_num = img_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
endmodule

// File: doc/core_frame_reader.md
# core_frame_reader

Core-domain consumer of the ping-pong frame buffer. On each bank-swap pulse it walks a decimated region of interest (ROI) of the 640×480 frame through the buffer's core read port. The read port has a fixed 2-cycle latency. The block emits the ROI as an OUT_W×OUT_H pixel stream with valid/ready backpressure and start/end markers, feeding the LeNet input stage.

## Interface
Parameters:
- ADDR_WIDTH, 19, frame-buffer address width
- DATA_WIDTH, 8, pixel width
- IMG_W, 640, source frame width
- IMG_H, 480, source frame height
- OUT_W, 28, output columns
- OUT_H, 28, output rows
- X0, 250, ROI first column
- Y0, 170, ROI first row
- STEP, 5, decimation stride, both axes
- RD_LAT, 2, frame-buffer core read latency in cycles
- FIFO_DEPTH, 4, return FIFO depth; must be ≥ RD_LAT+2

Ports:
- c_clk  in  1  core clock; the only clock
- arst_c_n  in  1  asynchronous active-low reset
- swap_c  in  1  1-cycle pulse: a new frame is readable
- image_num_c  in  4  image number of the readable bank
- addr_c  out  ADDR_WIDTH  read address to the frame buffer
- dout_c  in  DATA_WIDTH  read data, RD_LAT cycles after addr_c
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  pixel
- m_sof  out  1  first beat of frame
- m_eol  out  1  last beat of row
- m_eof  out  1  last beat of frame
- m_image_num  out  4  image number latched at frame start
- busy  out  1  a frame is in progress
- overrun  out  1  1-cycle pulse: swap_c arrived while busy

## Operation
- FSM states:
  - IDLE: on swap_c, go to RUN. Latch image_num_c into m_image_num. Load row_base = Y0·IMG_W+X0, addr_c = row_base, col = 0, row = 0.
  - RUN: issue reads, one address per cycle.
  - DRAIN: entered after the last address (col = OUT_W−1, row = OUT_H−1) is issued. Return to IDLE once inflight = 0, the FIFO is empty and the final beat has been accepted.
- Issue rule: an address issues only when fifo_count + inflight < FIFO_DEPTH. This guarantees no returned data is ever dropped.
- Tag pipeline: an RD_LAT-deep shift register carries {valid, sof, eol, eof} alongside each issued address. When the tag exits, dout_c is written into the FIFO with its tag.
- Address arithmetic uses adders only, no multipliers:
  - Advance within a row: addr_c += STEP.
  - At row end: row_base += STEP·IMG_W, then addr_c = row_base.
  - All sums are ADDR_WIDTH bits.
  - Elaboration check: X0+(OUT_W−1)·STEP < IMG_W and Y0+(OUT_H−1)·STEP < IMG_H.
- Marker values:
  - m_sof = (row 0, col 0).
  - m_eol = (col OUT_W−1).
  - m_eof = (row OUT_H−1, col OUT_W−1).
- swap_c in RUN or DRAIN: ignored for reading, overrun pulses for 1 cycle, and the frame in progress completes unchanged.
- swap_c in the cycle the FSM returns to IDLE counts as busy: it is ignored and flagged with overrun.
- Reset values: state IDLE, addr_c = 0, m_valid = 0, m_sof = m_eol = m_eof = 0, m_data = 0, m_image_num = 0, busy = 0, overrun = 0, FIFO and tag pipeline empty.
- Reset mid-frame: the frame is abandoned and no partial beats appear after reset is released.

## Timing
- swap_c high in cycle 0 → busy and the first addr_c appear in cycle 1.
- First data is on dout_c in cycle 1+RD_LAT and written to the FIFO at the end of that cycle.
- m_valid first rises in cycle 2+RD_LAT, which is cycle 4 with defaults.
- With m_ready held at 1: one beat per cycle, OUT_W·OUT_H = 784 consecutive beats, no bubbles.
- busy falls in the cycle after the m_eof handshake.
- Stream hold rule: m_valid, m_data and all markers stay stable while m_valid=1 and m_ready=0.
- When m_ready is low, issue stalls within one cycle of the FIFO-plus-inflight budget filling.

## Structure
- The package pseudo_sensor_pkg holds:
  - the IMG_W, IMG_H and ADDR_WIDTH defaults;
  - the FSM state enumeration (IDLE, RUN, DRAIN);
  - the beat tag struct {sof, eol, eof}.
- One sub-module, stream_return_fifo: a synchronous FIFO of FIFO_DEPTH entries of {tag, DATA_WIDTH}, first-word-fall-through, with a count output.

## Test plan
- Single frame, m_ready=1 → exactly 784 beats in 784 consecutive cycles, first m_valid at cycle 4.
  - Beat 0 carries the byte at address 170·640+250 = 109050; beat 1 at 109055; beat 28 at 112250.
  - m_sof only on beat 0; m_eol on beats 27, 55, …; m_eof only on beat 783.
- Random m_ready (50% duty) → same 784 values in order, no loss or duplication, payload stable under stall, inflight never exceeds the FIFO budget.
- m_ready held 0 for 100 cycles mid-frame → addr_c freezes after at most FIFO_DEPTH issues; streaming resumes with no gap in values.
- swap_c pulsed at beat 300 with image_num_c=7 → overrun pulses once; the frame finishes with the originally latched m_image_num (e.g. 3); no second frame starts.
- arst_c_n asserted at beat 400 → all outputs at reset values immediately. After release, the next swap_c produces a clean frame starting at m_sof with address 109050.
